sata_axil_cmd_master: RTL and testbench
=======================================

// Module: sata_axil_cmd_master
// PURPOSE
//  AXI4-Lite master that turns single-beat register commands from user logic into
//  AXI4-Lite read/write transactions toward the SATA control-register slave.
//  One transaction is outstanding at a time; results go back on a response channel.
//  A watchdog aborts transactions that stall, so a hung slave cannot lock up the host.
// PARAMETERS
//  AXI_DATA_WIDTH  32    data bus width; multiple of 8
//  AXI_ADDR_WIDTH  5     byte address width; matches the control-register slave
//  TIMEOUT_CYCLES  1024  cycles allowed from command accept to B/R completion; 0 disables
// PORTS
//  clk               in   1    single clock (also drives the AXI side)
//  rst               in   1    asynchronous, active-high reset
//  cmd_valid         in   1    command present
//  cmd_ready         out  1    command accepted when cmd_valid && cmd_ready
//  cmd_write         in   1    1 = write, 0 = read
//  cmd_addr          in   AW   byte address
//  cmd_wdata         in   DW   write data
//  cmd_wstrb         in   DW/8 write byte strobes
//  rsp_valid         out  1    response present
//  rsp_ready         in   1    response consumed when rsp_valid && rsp_ready
//  rsp_rdata         out  DW   read data; 0 for writes and timeouts
//  rsp_resp          out  2    AXI BRESP/RRESP; 2'b10 forced on timeout
//  rsp_timeout       out  1    1 = transaction aborted by watchdog
//  m_axi_awaddr/awprot/awvalid out, awready in     AXI4-Lite write address (awprot = 3'b000)
//  m_axi_wdata/wstrb/wvalid out, wready in         AXI4-Lite write data
//  m_axi_bresp in 2, m_axi_bvalid in, m_axi_bready out   write response
//  m_axi_araddr/arprot/arvalid out, arready in     AXI4-Lite read address (arprot = 3'b000)
//  m_axi_rdata in DW, m_axi_rresp in 2, m_axi_rvalid in, m_axi_rready out   read data
// BEHAVIOUR
//  Reset: state IDLE; cmd_ready=1; rsp_valid=0, rsp_rdata=0, rsp_resp=0, rsp_timeout=0;
//   all m_axi_*valid/ready=0; addr/data/strb registers 0; watchdog 0.
//  States: IDLE, WR (AW and/or W pending), WB (wait B), RA (AR pending), RD (wait R), RSP.
//  IDLE: cmd_ready=1. On accept: latch addr/data/strb; write -> WR with awvalid=wvalid=1
//   next cycle; read -> RA with arvalid=1 next cycle. Watchdog cleared at accept.
//  WR: awvalid drops the cycle after awready is sampled high, wvalid likewise with
//   wready; the two are independent (either order, or same cycle). When both done -> WB,
//   bready=1. valid never deasserts before its ready; payload stable while valid.
//  WB: on bvalid -> capture bresp, bready=0, rsp_rdata=0 -> RSP.
//  RA: arvalid held until arready -> RD, rready=1. RD: on rvalid capture rdata/rresp -> RSP.
//  RSP: rsp_valid=1, cmd_ready=0; on rsp_ready -> IDLE. Back-to-back: next command
//   accepted no earlier than the cycle after the response handshake.
//  Latency with zero-wait slave: accept at cycle 0, valid at 1, B/R at 2 earliest,
//   rsp_valid at 3.
//  Watchdog: counts every cycle in WR/WB/RA/RD; when it reaches TIMEOUT_CYCLES -> drop all
//   m_axi valid/ready, rsp_resp=2'b10, rsp_timeout=1, rsp_rdata=0 -> RSP. A handshake in
//   the same cycle as expiry wins (normal completion). Late B/R after abort is ignored
//   (bready/rready low). Saturating counter; TIMEOUT_CYCLES=0 never fires.
//  No inbound combinational path from cmd_* or m_axi_* to any output; all outputs registered.
//  rst mid-transaction: everything returns to reset values immediately; no response issued.
// TESTING
//  Write 0x04<=0xDEADBEEF strb 4'hF, zero-wait slave -> one AW+W beat, rsp_valid at cycle 3,
//   rsp_resp=00, rsp_timeout=0.
//  Write with awready delayed 5 cycles, wready 0 cycles -> wvalid drops after 1 beat,
//   awvalid held 5 cycles with stable addr; exactly one B; single response.
//  Read 0x10, slave returns 0x12345678 RRESP=10 after 3 cycles -> rsp_rdata=0x12345678,
//   rsp_resp=10.
//  Read with no arready, TIMEOUT_CYCLES=16 -> arvalid drops after 16 cycles, rsp_resp=10,
//   rsp_timeout=1, rsp_rdata=0; later rvalid ignored.
//  rsp_ready held low 10 cycles while cmd_valid=1 -> cmd_ready=0 throughout, no new AXI traffic.
//  rst pulsed while in WB -> bready, rsp_valid, cmd_ready return to 0/0/1 asynchronously.

Source files
------------

// File: rtl/sata_axil_cmd_master.sv
`default_nettype none
// ============================================================================
// Module      : sata_axil_cmd_master
// Description : AXI4-Lite master that turns single-beat register commands into
//               AXI4-Lite read/write transactions toward the SATA control-
//               register slave. One transaction is in flight at a time; a
//               watchdog aborts transactions that stall.
// Revision    : 1.0 - initial release
// ============================================================================
module sata_axil_cmd_master #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 5,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    // command channel
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_write,
    input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
    // response channel
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                  rsp_resp,
    output logic                        rsp_timeout,
    // AXI4-Lite write address
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]                  m_axi_awprot,
    output logic                        m_axi_awvalid,
    input  logic                        m_axi_awready,
    // AXI4-Lite write data
    output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                        m_axi_wvalid,
    input  logic                        m_axi_wready,
    // AXI4-Lite write response
    input  logic [1:0]                  m_axi_bresp,
    input  logic                        m_axi_bvalid,
    output logic                        m_axi_bready,
    // AXI4-Lite read address
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [2:0]                  m_axi_arprot,
    output logic                        m_axi_arvalid,
    input  logic                        m_axi_arready,
    // AXI4-Lite read data
    input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                  m_axi_rresp,
    input  logic                        m_axi_rvalid,
    output logic                        m_axi_rready
);

    localparam int c_strb_w = AXI_DATA_WIDTH / 8;
    // Counter only needs to reach TIMEOUT_CYCLES; keep at least one bit so a
    // disabled watchdog still elaborates.
    localparam int c_wd_w = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic c_wd_en = (TIMEOUT_CYCLES != 0);
    localparam logic [c_wd_w-1:0] c_wd_last =
        (TIMEOUT_CYCLES == 0) ? '0 : c_wd_w'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] c_resp_slverr = 2'b10;

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_wr   = 3'd1;
    localparam logic [2:0] c_st_wb   = 3'd2;
    localparam logic [2:0] c_st_ra   = 3'd3;
    localparam logic [2:0] c_st_rd   = 3'd4;
    localparam logic [2:0] c_st_rsp  = 3'd5;

    logic [2:0]                r_state,       w_state;
    logic [AXI_ADDR_WIDTH-1:0] r_addr,        w_addr;
    logic [AXI_DATA_WIDTH-1:0] r_wdata,       w_wdata;
    logic [c_strb_w-1:0]       r_wstrb,       w_wstrb;
    logic                      r_awvalid,     w_awvalid;
    logic                      r_wvalid,      w_wvalid;
    logic                      r_bready,      w_bready;
    logic                      r_arvalid,     w_arvalid;
    logic                      r_rready,      w_rready;
    logic                      r_cmd_ready,   w_cmd_ready;
    logic                      r_rsp_valid,   w_rsp_valid;
    logic [AXI_DATA_WIDTH-1:0] r_rsp_rdata,   w_rsp_rdata;
    logic [1:0]                r_rsp_resp,    w_rsp_resp;
    logic                      r_rsp_timeout, w_rsp_timeout;
    logic [c_wd_w-1:0]         r_wd,          w_wd;

    logic w_busy;
    logic w_done;
    logic w_expire;

    // Next-state and next-output logic; every output is registered from these.
    always_comb begin
        w_state       = r_state;
        w_addr        = r_addr;
        w_wdata       = r_wdata;
        w_wstrb       = r_wstrb;
        w_awvalid     = r_awvalid;
        w_wvalid      = r_wvalid;
        w_bready      = r_bready;
        w_arvalid     = r_arvalid;
        w_rready      = r_rready;
        w_cmd_ready   = r_cmd_ready;
        w_rsp_valid   = r_rsp_valid;
        w_rsp_rdata   = r_rsp_rdata;
        w_rsp_resp    = r_rsp_resp;
        w_rsp_timeout = r_rsp_timeout;
        w_wd          = r_wd;

        w_busy = (r_state == c_st_wr) || (r_state == c_st_wb) ||
                 (r_state == c_st_ra) || (r_state == c_st_rd);
        // A completing B/R handshake beats a watchdog expiry in the same cycle.
        w_done = ((r_state == c_st_wb) && m_axi_bvalid) ||
                 ((r_state == c_st_rd) && m_axi_rvalid);
        w_expire = c_wd_en && w_busy && (r_wd == c_wd_last);

        if (w_busy && (r_wd != '1)) begin
            w_wd = r_wd + 1'b1;
        end

        case (r_state)
            c_st_idle: begin
                if (cmd_valid && r_cmd_ready) begin
                    w_addr      = cmd_addr;
                    w_wdata     = cmd_wdata;
                    w_wstrb     = cmd_wstrb;
                    w_cmd_ready = 1'b0;
                    w_wd        = '0;
                    if (cmd_write) begin
                        w_state   = c_st_wr;
                        w_awvalid = 1'b1;
                        w_wvalid  = 1'b1;
                    end else begin
                        w_state   = c_st_ra;
                        w_arvalid = 1'b1;
                    end
                end
            end
            c_st_wr: begin
                // AW and W retire independently, in any order.
                w_awvalid = r_awvalid & ~m_axi_awready;
                w_wvalid  = r_wvalid & ~m_axi_wready;
                if (!w_awvalid && !w_wvalid) begin
                    w_state  = c_st_wb;
                    w_bready = 1'b1;
                end
            end
            c_st_wb: begin
                if (m_axi_bvalid) begin
                    w_bready      = 1'b0;
                    w_rsp_valid   = 1'b1;
                    w_rsp_rdata   = '0;
                    w_rsp_resp    = m_axi_bresp;
                    w_rsp_timeout = 1'b0;
                    w_state       = c_st_rsp;
                end
            end
            c_st_ra: begin
                if (m_axi_arready) begin
                    w_arvalid = 1'b0;
                    w_rready  = 1'b1;
                    w_state   = c_st_rd;
                end
            end
            c_st_rd: begin
                if (m_axi_rvalid) begin
                    w_rready      = 1'b0;
                    w_rsp_valid   = 1'b1;
                    w_rsp_rdata   = m_axi_rdata;
                    w_rsp_resp    = m_axi_rresp;
                    w_rsp_timeout = 1'b0;
                    w_state       = c_st_rsp;
                end
            end
            c_st_rsp: begin
                if (rsp_ready) begin
                    w_rsp_valid = 1'b0;
                    w_cmd_ready = 1'b1;
                    w_state     = c_st_idle;
                end
            end
            default: begin
                w_awvalid   = 1'b0;
                w_wvalid    = 1'b0;
                w_bready    = 1'b0;
                w_arvalid   = 1'b0;
                w_rready    = 1'b0;
                w_rsp_valid = 1'b0;
                w_cmd_ready = 1'b1;
                w_state     = c_st_idle;
            end
        endcase

        // Watchdog abort: release the bus and report a synthetic SLVERR.
        if (w_expire && !w_done) begin
            w_awvalid     = 1'b0;
            w_wvalid      = 1'b0;
            w_bready      = 1'b0;
            w_arvalid     = 1'b0;
            w_rready      = 1'b0;
            w_rsp_valid   = 1'b1;
            w_rsp_rdata   = '0;
            w_rsp_resp    = c_resp_slverr;
            w_rsp_timeout = 1'b1;
            w_state       = c_st_rsp;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state;
        end
    end

    // Payload, handshake and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr        <= '0;
            r_wdata       <= '0;
            r_wstrb       <= '0;
            r_awvalid     <= 1'b0;
            r_wvalid      <= 1'b0;
            r_bready      <= 1'b0;
            r_arvalid     <= 1'b0;
            r_rready      <= 1'b0;
            r_cmd_ready   <= 1'b1;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_resp    <= 2'b00;
            r_rsp_timeout <= 1'b0;
            r_wd          <= '0;
        end else begin
            r_addr        <= w_addr;
            r_wdata       <= w_wdata;
            r_wstrb       <= w_wstrb;
            r_awvalid     <= w_awvalid;
            r_wvalid      <= w_wvalid;
            r_bready      <= w_bready;
            r_arvalid     <= w_arvalid;
            r_rready      <= w_rready;
            r_cmd_ready   <= w_cmd_ready;
            r_rsp_valid   <= w_rsp_valid;
            r_rsp_rdata   <= w_rsp_rdata;
            r_rsp_resp    <= w_rsp_resp;
            r_rsp_timeout <= w_rsp_timeout;
            r_wd          <= w_wd;
        end
    end

    assign cmd_ready     = r_cmd_ready;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_rdata     = r_rsp_rdata;
    assign rsp_resp      = r_rsp_resp;
    assign rsp_timeout   = r_rsp_timeout;

    assign m_axi_awaddr  = r_addr;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = r_wstrb;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_bready  = r_bready;
    assign m_axi_araddr  = r_addr;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = r_arvalid;
    assign m_axi_rready  = r_rready;

endmodule
`default_nettype wire

// File: tb/tb_sata_axil_cmd_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_sata_axil_cmd_master
// Description : Directed self-checking bench for sata_axil_cmd_master. The
//               slave side is driven cycle by cycle from each scenario task;
//               inputs change and outputs are sampled on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sata_axil_cmd_master;

    localparam int c_dw = 32;
    localparam int c_aw = 5;

    logic              clk;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [c_aw-1:0]   cmd_addr;
    logic [c_dw-1:0]   cmd_wdata;
    logic [c_dw/8-1:0] cmd_wstrb;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [c_dw-1:0]   rsp_rdata;
    logic [1:0]        rsp_resp;
    logic              rsp_timeout;
    logic [c_aw-1:0]   m_axi_awaddr;
    logic [2:0]        m_axi_awprot;
    logic              m_axi_awvalid;
    logic              m_axi_awready;
    logic [c_dw-1:0]   m_axi_wdata;
    logic [c_dw/8-1:0] m_axi_wstrb;
    logic              m_axi_wvalid;
    logic              m_axi_wready;
    logic [1:0]        m_axi_bresp;
    logic              m_axi_bvalid;
    logic              m_axi_bready;
    logic [c_aw-1:0]   m_axi_araddr;
    logic [2:0]        m_axi_arprot;
    logic              m_axi_arvalid;
    logic              m_axi_arready;
    logic [c_dw-1:0]   m_axi_rdata;
    logic [1:0]        m_axi_rresp;
    logic              m_axi_rvalid;
    logic              m_axi_rready;

    int nvec;
    int nfail;

    sata_axil_cmd_master #(
        .AXI_DATA_WIDTH (c_dw),
        .AXI_ADDR_WIDTH (c_aw),
        .TIMEOUT_CYCLES (16)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .cmd_wstrb     (cmd_wstrb),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_resp      (rsp_resp),
        .rsp_timeout   (rsp_timeout),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awprot  (m_axi_awprot),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arprot  (m_axi_arprot),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic test_reset();
        rst = 1'b0;
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        rsp_ready = 0; m_axi_awready = 0; m_axi_wready = 0; m_axi_bresp = 0; m_axi_bvalid = 0;
        m_axi_arready = 0; m_axi_rdata = '0; m_axi_rresp = 0; m_axi_rvalid = 0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        nvec++; if (cmd_ready !== 1'b1) begin nfail++; $display("FAIL rst_cmd_ready got=%0h want=1", cmd_ready); end
        nvec++; if (rsp_valid !== 1'b0) begin nfail++; $display("FAIL rst_rsp_valid got=%0h want=0", rsp_valid); end
        nvec++; if (rsp_rdata !== 32'h0) begin nfail++; $display("FAIL rst_rsp_rdata got=%0h want=0", rsp_rdata); end
        nvec++; if ({rsp_resp, rsp_timeout} !== 3'b000) begin nfail++; $display("FAIL rst_resp_to got=%0h want=0", {rsp_resp, rsp_timeout}); end
        nvec++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready} !== 5'b0) begin
            nfail++; $display("FAIL rst_axi_hs got=%0h want=0", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}); end
        nvec++; if ({m_axi_awaddr, m_axi_wdata, m_axi_wstrb} !== 41'h0) begin nfail++; $display("FAIL rst_payload got=%0h want=0", {m_axi_awaddr, m_axi_wdata, m_axi_wstrb}); end
        nvec++; if ({m_axi_awprot, m_axi_arprot} !== 6'b0) begin nfail++; $display("FAIL rst_prot got=%0h want=0", {m_axi_awprot, m_axi_arprot}); end
        rst = 1'b0;
    endtask

    task automatic test_write_zero_wait();
        @(negedge clk);
        cmd_valid = 1; cmd_write = 1; cmd_addr = 5'h04; cmd_wdata = 32'hDEADBEEF; cmd_wstrb = 4'hF;
        m_axi_awready = 1; m_axi_wready = 1;
        @(negedge clk); // cycle 1
        nvec++; if ({m_axi_awvalid, m_axi_wvalid} !== 2'b11) begin nfail++; $display("FAIL wz_c1_valids got=%0h want=3", {m_axi_awvalid, m_axi_wvalid}); end
        nvec++; if (m_axi_awaddr !== 5'h04) begin nfail++; $display("FAIL wz_awaddr got=%0h want=4", m_axi_awaddr); end
        nvec++; if (m_axi_wdata !== 32'hDEADBEEF) begin nfail++; $display("FAIL wz_wdata got=%0h want=deadbeef", m_axi_wdata); end
        nvec++; if (m_axi_wstrb !== 4'hF) begin nfail++; $display("FAIL wz_wstrb got=%0h want=f", m_axi_wstrb); end
        nvec++; if (cmd_ready !== 1'b0) begin nfail++; $display("FAIL wz_c1_cmd_ready got=%0h want=0", cmd_ready); end
        cmd_valid = 0;
        @(negedge clk); // cycle 2
        nvec++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready} !== 3'b001) begin nfail++; $display("FAIL wz_c2_hs got=%0h want=1", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}); end
        nvec++; if (rsp_valid !== 1'b0) begin nfail++; $display("FAIL wz_c2_rsp_valid got=%0h want=0", rsp_valid); end
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 1; m_axi_bresp = 2'b00;
        @(negedge clk); // cycle 3
        nvec++; if (rsp_valid !== 1'b1) begin nfail++; $display("FAIL wz_c3_rsp_valid got=%0h want=1", rsp_valid); end
        nvec++; if ({rsp_resp, rsp_timeout} !== 3'b000) begin nfail++; $display("FAIL wz_c3_resp_to got=%0h want=0", {rsp_resp, rsp_timeout}); end
        nvec++; if (rsp_rdata !== 32'h0) begin nfail++; $display("FAIL wz_c3_rdata got=%0h want=0", rsp_rdata); end
        nvec++; if ({m_axi_bready, cmd_ready} !== 2'b00) begin nfail++; $display("FAIL wz_c3_bready_cmdrdy got=%0h want=0", {m_axi_bready, cmd_ready}); end
        m_axi_bvalid = 0; rsp_ready = 1;
        @(negedge clk); // cycle 4
        nvec++; if ({rsp_valid, cmd_ready} !== 2'b01) begin nfail++; $display("FAIL wz_c4_idle got=%0h want=1", {rsp_valid, cmd_ready}); end
        rsp_ready = 0;
    endtask

    task automatic test_read_delay();
        @(negedge clk);
        cmd_valid = 1; cmd_write = 0; cmd_addr = 5'h10;
        @(negedge clk); // cycle 1
        nvec++; if ({m_axi_arvalid, m_axi_awvalid, m_axi_wvalid} !== 3'b100) begin nfail++; $display("FAIL rd_c1_valids got=%0h want=4", {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid}); end
        nvec++; if (m_axi_araddr !== 5'h10) begin nfail++; $display("FAIL rd_araddr got=%0h want=10", m_axi_araddr); end
        cmd_valid = 0; m_axi_arready = 1;
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            m_axi_arready = 0;
            nvec++; if ({m_axi_arvalid, m_axi_rready, rsp_valid} !== 3'b010) begin nfail++; $display("FAIL rd_wait%0d got=%0h want=2", k, {m_axi_arvalid, m_axi_rready, rsp_valid}); end
        end
        m_axi_rvalid = 1; m_axi_rdata = 32'h12345678; m_axi_rresp = 2'b10;
        @(negedge clk); // cycle 5
        nvec++; if (rsp_valid !== 1'b1) begin nfail++; $display("FAIL rd_rsp_valid got=%0h want=1", rsp_valid); end
        nvec++; if (rsp_rdata !== 32'h12345678) begin nfail++; $display("FAIL rd_rdata got=%0h want=12345678", rsp_rdata); end
        nvec++; if ({rsp_resp, rsp_timeout} !== 3'b100) begin nfail++; $display("FAIL rd_resp_to got=%0h want=4", {rsp_resp, rsp_timeout}); end
        nvec++; if (m_axi_rready !== 1'b0) begin nfail++; $display("FAIL rd_rready_drop got=%0h want=0", m_axi_rready); end
        m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rresp = 0; rsp_ready = 1;
        @(negedge clk);
        nvec++; if ({rsp_valid, cmd_ready} !== 2'b01) begin nfail++; $display("FAIL rd_idle got=%0h want=1", {rsp_valid, cmd_ready}); end
        rsp_ready = 0;
    endtask

    task automatic test_write_aw_delay();
        @(negedge clk);
        cmd_valid = 1; cmd_write = 1; cmd_addr = 5'h18; cmd_wdata = 32'h0BADF00D; cmd_wstrb = 4'h6;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            nvec++; if (m_axi_awvalid !== 1'b1) begin nfail++; $display("FAIL awd_awvalid%0d got=%0h want=1", k, m_axi_awvalid); end
            nvec++; if (m_axi_awaddr !== 5'h18) begin nfail++; $display("FAIL awd_awaddr%0d got=%0h want=18", k, m_axi_awaddr); end
            nvec++; if (m_axi_wvalid !== (k == 1)) begin nfail++; $display("FAIL awd_wvalid%0d got=%0h want=%0h", k, m_axi_wvalid, (k == 1)); end
            nvec++; if (m_axi_bready !== 1'b0) begin nfail++; $display("FAIL awd_bready%0d got=%0h want=0", k, m_axi_bready); end
            cmd_valid = 0;
            m_axi_wready = (k == 1);
            m_axi_awready = (k == 5);
        end
        @(negedge clk); // cycle 6
        nvec++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready} !== 3'b001) begin nfail++; $display("FAIL awd_c6_hs got=%0h want=1", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}); end
        m_axi_awready = 0; m_axi_bvalid = 1; m_axi_bresp = 2'b11;
        @(negedge clk); // cycle 7
        nvec++; if ({rsp_valid, m_axi_bready} !== 2'b10) begin nfail++; $display("FAIL awd_c7_rsp got=%0h want=2", {rsp_valid, m_axi_bready}); end
        nvec++; if ({rsp_resp, rsp_timeout} !== 3'b110) begin nfail++; $display("FAIL awd_resp_to got=%0h want=6", {rsp_resp, rsp_timeout}); end
        nvec++; if (rsp_rdata !== 32'h0) begin nfail++; $display("FAIL awd_rdata got=%0h want=0", rsp_rdata); end
        m_axi_bvalid = 0; m_axi_bresp = 0; rsp_ready = 1;
        @(negedge clk);
        nvec++; if ({rsp_valid, cmd_ready} !== 2'b01) begin nfail++; $display("FAIL awd_idle got=%0h want=1", {rsp_valid, cmd_ready}); end
        rsp_ready = 0;
    endtask

    task automatic test_read_timeout();
        @(negedge clk);
        cmd_valid = 1; cmd_write = 0; cmd_addr = 5'h1C;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            nvec++; if ({m_axi_arvalid, rsp_valid} !== 2'b10) begin nfail++; $display("FAIL to_wait%0d got=%0h want=2", k, {m_axi_arvalid, rsp_valid}); end
            cmd_valid = 0;
        end
        @(negedge clk); // cycle 17
        nvec++; if ({m_axi_arvalid, m_axi_rready} !== 2'b00) begin nfail++; $display("FAIL to_drop got=%0h want=0", {m_axi_arvalid, m_axi_rready}); end
        nvec++; if (rsp_valid !== 1'b1) begin nfail++; $display("FAIL to_rsp_valid got=%0h want=1", rsp_valid); end
        nvec++; if ({rsp_resp, rsp_timeout} !== 3'b101) begin nfail++; $display("FAIL to_resp_to got=%0h want=5", {rsp_resp, rsp_timeout}); end
        nvec++; if (rsp_rdata !== 32'h0) begin nfail++; $display("FAIL to_rdata got=%0h want=0", rsp_rdata); end
        m_axi_rvalid = 1; m_axi_rdata = 32'hFFFF0000; m_axi_rresp = 2'b00;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            nvec++; if ({m_axi_rready, rsp_valid, rsp_resp, rsp_timeout} !== 5'b01101) begin nfail++; $display("FAIL to_late%0d got=%0h want=d", k, {m_axi_rready, rsp_valid, rsp_resp, rsp_timeout}); end
            nvec++; if (rsp_rdata !== 32'h0) begin nfail++; $display("FAIL to_late_rdata%0d got=%0h want=0", k, rsp_rdata); end
        end
        m_axi_rvalid = 0; m_axi_rdata = '0; rsp_ready = 1;
        @(negedge clk);
        nvec++; if ({rsp_valid, cmd_ready} !== 2'b01) begin nfail++; $display("FAIL to_idle got=%0h want=1", {rsp_valid, cmd_ready}); end
        rsp_ready = 0;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        cmd_valid = 1; cmd_write = 1; cmd_addr = 5'h0C; cmd_wdata = 32'hA5A50F0F; cmd_wstrb = 4'h3;
        m_axi_awready = 1; m_axi_wready = 1;
        @(negedge clk); // cycle 1: present the next command early
        cmd_write = 0; cmd_addr = 5'h08; cmd_wdata = 32'h0; cmd_wstrb = 4'h0;
        nvec++; if ({m_axi_awaddr, m_axi_wstrb} !== {5'h0C, 4'h3}) begin nfail++; $display("FAIL bb_latched got=%0h want=%0h", {m_axi_awaddr, m_axi_wstrb}, {5'h0C, 4'h3}); end
        @(negedge clk); // cycle 2
        nvec++; if (m_axi_bready !== 1'b1) begin nfail++; $display("FAIL bb_bready got=%0h want=1", m_axi_bready); end
        nvec++; if (m_axi_wdata !== 32'hA5A50F0F) begin nfail++; $display("FAIL bb_wdata_hold got=%0h want=a5a50f0f", m_axi_wdata); end
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 1;
        @(negedge clk); // cycle 3
        m_axi_bvalid = 0;
        for (int k = 0; k < 10; k++) begin
            nvec++; if ({cmd_ready, rsp_valid, m_axi_awvalid, m_axi_arvalid, rsp_timeout} !== 5'b01000) begin
                nfail++; $display("FAIL bb_hold%0d got=%0h want=8", k, {cmd_ready, rsp_valid, m_axi_awvalid, m_axi_arvalid, rsp_timeout}); end
            if (k == 9) rsp_ready = 1;
            @(negedge clk);
        end
        rsp_ready = 0;
        nvec++; if ({rsp_valid, cmd_ready, m_axi_arvalid} !== 3'b010) begin nfail++; $display("FAIL bb_release got=%0h want=2", {rsp_valid, cmd_ready, m_axi_arvalid}); end
        @(negedge clk);
        nvec++; if ({m_axi_arvalid, cmd_ready} !== 2'b10) begin nfail++; $display("FAIL bb_next_accept got=%0h want=2", {m_axi_arvalid, cmd_ready}); end
        nvec++; if (m_axi_araddr !== 5'h08) begin nfail++; $display("FAIL bb_araddr got=%0h want=8", m_axi_araddr); end
        cmd_valid = 0; m_axi_arready = 1;
        @(negedge clk);
        m_axi_arready = 0; m_axi_rvalid = 1; m_axi_rdata = 32'hCAFE0001; m_axi_rresp = 2'b00;
        @(negedge clk);
        nvec++; if ({rsp_valid, rsp_resp, rsp_timeout} !== 4'b1000) begin nfail++; $display("FAIL bb_rd_rsp got=%0h want=8", {rsp_valid, rsp_resp, rsp_timeout}); end
        nvec++; if (rsp_rdata !== 32'hCAFE0001) begin nfail++; $display("FAIL bb_rd_rdata got=%0h want=cafe0001", rsp_rdata); end
        m_axi_rvalid = 0; m_axi_rdata = '0; rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
    endtask

    task automatic test_reset_mid_wb();
        @(negedge clk);
        cmd_valid = 1; cmd_write = 1; cmd_addr = 5'h14; cmd_wdata = 32'h11223344; cmd_wstrb = 4'hF;
        m_axi_awready = 1; m_axi_wready = 1;
        @(negedge clk);
        cmd_valid = 0;
        @(negedge clk); // in WB
        m_axi_awready = 0; m_axi_wready = 0;
        nvec++; if (m_axi_bready !== 1'b1) begin nfail++; $display("FAIL rm_in_wb got=%0h want=1", m_axi_bready); end
        #2 rst = 1'b1;
        #1;
        nvec++; if ({m_axi_bready, rsp_valid, cmd_ready} !== 3'b001) begin nfail++; $display("FAIL rm_async got=%0h want=1", {m_axi_bready, rsp_valid, cmd_ready}); end
        nvec++; if ({m_axi_awaddr, m_axi_wdata} !== 37'h0) begin nfail++; $display("FAIL rm_payload got=%0h want=0", {m_axi_awaddr, m_axi_wdata}); end
        #1 rst = 1'b0;
        m_axi_bvalid = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            nvec++; if ({rsp_valid, m_axi_bready, cmd_ready} !== 3'b001) begin nfail++; $display("FAIL rm_quiet%0d got=%0h want=1", k, {rsp_valid, m_axi_bready, cmd_ready}); end
        end
        m_axi_bvalid = 0;
    endtask

    initial begin
        nvec  = 0;
        nfail = 0;
        test_reset();
        test_write_zero_wait();
        test_read_delay();
        test_write_aw_delay();
        test_read_timeout();
        test_back_to_back();
        test_reset_mid_wb();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
`default_nettype wire
